// File: rtl/ntp_time_regs_pkg.sv
// Shared constants for the ntp_time_regs AXI4-Lite register block.
// Optional feature macro: NTP_TIME_REGS_UPD_CNT_EN (adds the UPD_CNT register).
package ntp_time_regs_pkg;

   localparam logic [2:0] ADDR_VERSION = 3'd0;
   localparam logic [2:0] ADDR_STATUS  = 3'd1;
   localparam logic [2:0] ADDR_TIME_HI = 3'd2;
   localparam logic [2:0] ADDR_TIME_LO = 3'd3;
   localparam logic [2:0] ADDR_UPD_CNT = 3'd4;

   localparam int STAT_SYNC_OK    = 0;
   localparam int STAT_PLL_LOCKED = 1;
   localparam int STAT_SYNC_LOST  = 2;
   localparam int STAT_PLL_LOST   = 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Words above the last implemented register answer with SLVERR.
   function automatic logic is_mapped(input logic [2:0] word);
`ifdef NTP_TIME_REGS_UPD_CNT_EN
      return word <= ADDR_UPD_CNT;
`else
      return word <= ADDR_TIME_LO;
`endif
   endfunction

endpackage

// File: rtl/ntp_time_regs_if.sv
// AXI4-Lite bus (32-bit data, 5-bit address) between the PCIe-AXI bridge and ntp_time_regs.
interface ntp_time_regs_if;

   logic [4:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [4:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/ntp_time_regs_sync2.sv
// Two-flop synchronizer with synchronous active-low reset for asynchronous status inputs.
module ntp_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments so q takes the old meta, giving two real flop stages.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ntp_time_regs.sv
// AXI4-Lite register slave giving software coherent NTP time snapshots and lock status.
// Define NTP_TIME_REGS_UPD_CNT_EN to add the UPD_CNT time-update counter at 0x10.
module ntp_time_regs
   import ntp_time_regs_pkg::*;
#(
   parameter logic [31:0] VERSION = 32'h0001_0000
) (
   input  logic          axi_aclk,
   input  logic          axi_aresetn,
   ntp_time_regs_if.slave axi,
   input  logic [63:0]   ntp_time,
   input  logic          ntp_time_upd,
   input  logic          sync_ok,
   input  logic          pll_locked
);

   logic        sync_ok_s, pll_locked_s;
   logic        sync_ok_q, pll_locked_q;
   logic        sync_lost, pll_lost;
   logic [63:0] time_cap;
   logic [31:0] lo_shadow;

   logic        wr_go, bvalid, rd_go, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   logic        wr_fire, wr_en, rd_fire, status_wr;
   logic [2:0]  wr_word, rd_word;
   logic [31:0] status, rd_val;

   ntp_sync2 u_sync_ok (
      .clk   (axi_aclk),
      .rst_n (axi_aresetn),
      .d     (sync_ok),
      .q     (sync_ok_s)
   );

   ntp_sync2 u_sync_pll (
      .clk   (axi_aclk),
      .rst_n (axi_aresetn),
      .d     (pll_locked),
      .q     (pll_locked_s)
   );

   // Ready lines are registered one-cycle pulses; the handshake completes while they are high.
   assign wr_word   = axi.awaddr[4:2];
   assign rd_word   = axi.araddr[4:2];
   assign wr_fire   = wr_go & axi.awvalid & axi.wvalid;
   assign rd_fire   = rd_go & axi.arvalid;
   assign wr_en     = wr_fire & axi.wstrb[0];
   assign status_wr = wr_en && (wr_word == ADDR_STATUS);

   assign axi.awready = wr_go;
   assign axi.wready  = wr_go;
   assign axi.bvalid  = bvalid;
   assign axi.bresp   = bresp;
   assign axi.arready = rd_go;
   assign axi.rvalid  = rvalid;
   assign axi.rdata   = rdata;
   assign axi.rresp   = rresp;

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         wr_go  <= 1'b0;
         bvalid <= 1'b0;
         bresp  <= RESP_OKAY;
         rd_go  <= 1'b0;
         rvalid <= 1'b0;
         rresp  <= RESP_OKAY;
         rdata  <= '0;
      end else begin
         wr_go <= axi.awvalid & axi.wvalid & ~wr_go & ~bvalid;
         if (wr_fire) begin
            bvalid <= 1'b1;
            bresp  <= is_mapped(wr_word) ? RESP_OKAY : RESP_SLVERR;
         end else if (axi.bready) begin
            bvalid <= 1'b0;
         end

         rd_go <= axi.arvalid & ~rd_go & ~rvalid;
         if (rd_fire) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= is_mapped(rd_word) ? RESP_OKAY : RESP_SLVERR;
         end else if (axi.rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   // Sticky loss flags: a falling edge in the same cycle as a W1C keeps the flag set.
   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         sync_ok_q    <= 1'b0;
         pll_locked_q <= 1'b0;
         sync_lost    <= 1'b0;
         pll_lost     <= 1'b0;
         time_cap     <= '0;
         lo_shadow    <= '0;
      end else begin
         sync_ok_q    <= sync_ok_s;
         pll_locked_q <= pll_locked_s;
         sync_lost    <= (sync_lost & ~(status_wr & axi.wdata[STAT_SYNC_LOST]))
                         | (sync_ok_q & ~sync_ok_s);
         pll_lost     <= (pll_lost & ~(status_wr & axi.wdata[STAT_PLL_LOST]))
                         | (pll_locked_q & ~pll_locked_s);
         if (ntp_time_upd)
            time_cap <= ntp_time;
         if (rd_fire && (rd_word == ADDR_TIME_HI))
            lo_shadow <= time_cap[31:0];
      end
   end

`ifdef NTP_TIME_REGS_UPD_CNT_EN
   logic [31:0] upd_cnt;
   logic        cnt_clr;

   assign cnt_clr = wr_en && (wr_word == ADDR_UPD_CNT);

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn)
         upd_cnt <= '0;
      else if (cnt_clr)
         upd_cnt <= {31'd0, ntp_time_upd};
      else if (ntp_time_upd)
         upd_cnt <= upd_cnt + 32'd1;
   end
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      status                  = '0;
      status[STAT_SYNC_OK]    = sync_ok_s;
      status[STAT_PLL_LOCKED] = pll_locked_s;
      status[STAT_SYNC_LOST]  = sync_lost;
      status[STAT_PLL_LOST]   = pll_lost;
   end

   always_comb begin
      rd_val = '0;
      case (rd_word)
         ADDR_VERSION: rd_val = VERSION;
         ADDR_STATUS:  rd_val = status;
         ADDR_TIME_HI: rd_val = time_cap[63:32];
         ADDR_TIME_LO: rd_val = lo_shadow;
`ifdef NTP_TIME_REGS_UPD_CNT_EN
         ADDR_UPD_CNT: rd_val = upd_cnt;
`endif
         default:      rd_val = '0;
      endcase
   end

   logic unused_ok;
   assign unused_ok = ^{axi.awprot, axi.arprot, axi.awaddr[1:0], axi.araddr[1:0],
                        axi.wstrb[3:1], axi.wdata[31:4], axi.wdata[1:0]};

endmodule

// File: tb/tb_ntp_time_regs.sv
// Directed, table-driven bench for ntp_time_regs; optional UPD_CNT checks follow NTP_TIME_REGS_UPD_CNT_EN.
module tb_ntp_time_regs;

   localparam int          TMO  = 50;
   localparam logic [1:0]  OK   = 2'b00;
   localparam logic [1:0]  ERR  = 2'b10;
   localparam logic [31:0] VER  = 32'h0001_0000;
`ifdef NTP_TIME_REGS_UPD_CNT_EN
   localparam logic [1:0]  CNT_RESP = OK;
`else
   localparam logic [1:0]  CNT_RESP = ERR;
`endif

   logic        axi_aclk;
   logic        axi_aresetn;
   logic [63:0] ntp_time;
   logic        ntp_time_upd;
   logic        sync_ok;
   logic        pll_locked;
   int          checks;
   int          errors;

   ntp_time_regs_if axi ();

   ntp_time_regs dut (
      .axi_aclk     (axi_aclk),
      .axi_aresetn  (axi_aresetn),
      .axi          (axi),
      .ntp_time     (ntp_time),
      .ntp_time_upd (ntp_time_upd),
      .sync_ok      (sync_ok),
      .pll_locked   (pll_locked)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          is_wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out after %0d cycles, expected a handshake", name, TMO);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge axi_aclk);
      #1;
   endtask

   task automatic pulse(input logic [63:0] t);
      ntp_time     = t;
      ntp_time_upd = 1'b1;
      @(posedge axi_aclk);
      #1;
      ntp_time_upd = 1'b0;
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit upd_at_accept, output logic [1:0] resp);
      int n = 0;
      resp        = 2'b11;
      axi.awaddr  = addr;
      axi.wdata   = data;
      axi.wstrb   = strb;
      axi.awvalid = 1'b1;
      axi.wvalid  = 1'b1;
      axi.bready  = 1'b1;
      do begin @(negedge axi_aclk); n++; end while (!axi.awready && n < TMO);
      if (!axi.awready) begin
         timeout("write_accept");
         axi.awvalid = 1'b0;
         axi.wvalid  = 1'b0;
         return;
      end
      if (upd_at_accept) ntp_time_upd = 1'b1;
      @(posedge axi_aclk);
      #1;
      axi.awvalid  = 1'b0;
      axi.wvalid   = 1'b0;
      ntp_time_upd = 1'b0;
      n = 0;
      do begin @(negedge axi_aclk); n++; end while (!axi.bvalid && n < TMO);
      if (!axi.bvalid) begin
         timeout("write_resp");
         return;
      end
      resp = axi.bresp;
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic do_read(input logic [4:0] addr, input bit upd_at_accept,
                          output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      data        = '1;
      resp        = 2'b11;
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      axi.rready  = 1'b1;
      do begin @(negedge axi_aclk); n++; end while (!axi.arready && n < TMO);
      if (!axi.arready) begin
         timeout("read_accept");
         axi.arvalid = 1'b0;
         return;
      end
      if (upd_at_accept) ntp_time_upd = 1'b1;
      @(posedge axi_aclk);
      #1;
      axi.arvalid  = 1'b0;
      ntp_time_upd = 1'b0;
      n = 0;
      do begin @(negedge axi_aclk); n++; end while (!axi.rvalid && n < TMO);
      if (!axi.rvalid) begin
         timeout("read_resp");
         return;
      end
      data = axi.rdata;
      resp = axi.rresp;
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic rd_check(input string name, input logic [4:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      logic [31:0] d;
      logic [1:0]  r;
      do_read(addr, 1'b0, d, r);
      check(name, {32'd0, d}, {32'd0, exp_data});
      check({name, "_resp"}, {62'd0, r}, {62'd0, exp_resp});
   endtask

   task automatic wr_check(input string name, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
      logic [1:0] r;
      do_write(addr, data, strb, 1'b0, r);
      check(name, {62'd0, r}, {62'd0, exp_resp});
   endtask

   function automatic logic [40:0] all_outputs();
      return {axi.awready, axi.wready, axi.bvalid, axi.bresp, axi.arready,
              axi.rvalid, axi.rresp, axi.rdata};
   endfunction

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      bit          seen;

      checks = 0;
      errors = 0;

      vecs[0]  = '{1'b0, 5'h00, 32'h0,         4'h0, VER,           OK};
      vecs[1]  = '{1'b0, 5'h03, 32'h0,         4'h0, VER,           OK};
      vecs[2]  = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h3,         OK};
      vecs[3]  = '{1'b0, 5'h14, 32'h0,         4'h0, 32'h0,         ERR};
      vecs[4]  = '{1'b0, 5'h18, 32'h0,         4'h0, 32'h0,         ERR};
      vecs[5]  = '{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0,         ERR};
      vecs[6]  = '{1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0,         ERR};
      vecs[7]  = '{1'b1, 5'h00, 32'hDEAD_BEEF, 4'hF, 32'h0,         OK};
      vecs[8]  = '{1'b1, 5'h08, 32'h0,         4'hF, 32'h0,         OK};
      vecs[9]  = '{1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0,         OK};
      vecs[10] = '{1'b0, 5'h00, 32'h0,         4'h0, VER,           OK};
      vecs[11] = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h3,         OK};
      vecs[12] = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h1234_5678, OK};
      vecs[13] = '{1'b1, 5'h10, 32'h0,         4'hF, 32'h0,         CNT_RESP};
      vecs[14] = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h0,         CNT_RESP};
      vecs[15] = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h3,         OK};

      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata  = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0; axi.bready = 1'b1;
      axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
      ntp_time = '0; ntp_time_upd = 1'b0; sync_ok = 1'b1; pll_locked = 1'b1;
      axi_aresetn = 1'b0;

      // Reset state, then STATUS read issued right at release sees empty synchronizers.
      repeat (3) @(posedge axi_aclk);
      @(negedge axi_aclk);
      check("reset_outputs", {23'd0, all_outputs()}, 64'd0);
      @(posedge axi_aclk);
      #1;
      axi_aresetn = 1'b1;
      rd_check("status_after_reset", 5'h04, 32'h0, OK);
      idle(4);
      rd_check("status_live", 5'h04, 32'h3, OK);

      // Atomic time snapshot through TIME_HI / lo_shadow.
      pulse(64'h0000_0001_8000_0000);
      rd_check("time_hi_1", 5'h08, 32'h0000_0001, OK);
      pulse(64'h0000_0002_0000_0000);
      rd_check("time_lo_old_frac", 5'h0C, 32'h8000_0000, OK);
      rd_check("time_hi_2", 5'h08, 32'h0000_0002, OK);
      rd_check("time_lo_2", 5'h0C, 32'h0000_0000, OK);
      ntp_time = 64'h0000_0003_1234_5678;
      do_read(5'h08, 1'b1, d, r);
      check("time_hi_strobe_at_accept", {32'd0, d}, 64'h2);
      rd_check("time_lo_strobe_at_accept", 5'h0C, 32'h0, OK);
      rd_check("time_hi_3", 5'h08, 32'h3, OK);
      rd_check("time_lo_3", 5'h0C, 32'h1234_5678, OK);

      // Status: synchronizer latency, sticky set, W1C with and without wstrb[0].
      sync_ok = 1'b0;
      rd_check("status_lag", 5'h04, 32'h3, OK);
      rd_check("sync_lost_set", 5'h04, 32'h6, OK);
      wr_check("w1c_nostrb_resp", 5'h04, 32'h4, 4'h0, OK);
      rd_check("w1c_nostrb_kept", 5'h04, 32'h6, OK);
      wr_check("w1c_resp", 5'h04, 32'h4, 4'hF, OK);
      rd_check("sync_lost_clr", 5'h04, 32'h2, OK);
      sync_ok    = 1'b1;
      pll_locked = 1'b0;
      idle(5);
      rd_check("pll_lost_set", 5'h04, 32'h9, OK);
      pll_locked = 1'b1;
      idle(5);
      rd_check("pll_relock", 5'h04, 32'hB, OK);
      wr_check("w1c_pll_resp", 5'h04, 32'h8, 4'h1, OK);
      rd_check("pll_lost_clr", 5'h04, 32'h3, OK);

      // Register map vectors.
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, r);
            check($sformatf("vec%0d_bresp", i), {62'd0, r}, {62'd0, vecs[i].exp_resp});
         end else begin
            do_read(vecs[i].addr, 1'b0, d, r);
            check($sformatf("vec%0d_rdata", i), {32'd0, d}, {32'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_rresp", i), {62'd0, r}, {62'd0, vecs[i].exp_resp});
         end
      end

      // Read backpressure: rvalid/rdata hold and a second arvalid waits.
      begin
         int n = 0;
         axi.rready  = 1'b0;
         axi.araddr  = 5'h00;
         axi.arvalid = 1'b1;
         do begin @(negedge axi_aclk); n++; end while (!axi.arready && n < TMO);
         if (!axi.arready) timeout("bp_accept");
         @(posedge axi_aclk);
         #1;
         axi.araddr = 5'h08;
         for (int i = 0; i < 10; i++) begin
            @(negedge axi_aclk);
            check($sformatf("bp_hold_%0d", i), {30'd0, axi.arready, axi.rvalid, axi.rdata},
                  {30'd0, 1'b0, 1'b1, VER});
         end
         axi.rready = 1'b1;
         @(posedge axi_aclk);
         #1;
         rd_check("bp_second_read", 5'h08, 32'h3, OK);
      end

      // awvalid without wvalid must not be accepted.
      seen        = 1'b0;
      axi.awaddr  = 5'h04;
      axi.wdata   = 32'h0;
      axi.wstrb   = 4'hF;
      axi.awvalid = 1'b1;
      axi.wvalid  = 1'b0;
      repeat (5) begin
         @(negedge axi_aclk);
         seen = seen | axi.awready | axi.wready;
      end
      check("aw_only_no_accept", {63'd0, seen}, 64'd0);
      @(posedge axi_aclk);
      #1;
      wr_check("aw_then_w_resp", 5'h04, 32'h0, 4'hF, OK);

`ifdef NTP_TIME_REGS_UPD_CNT_EN
      wr_check("cnt_clr_resp", 5'h10, 32'h0, 4'hF, OK);
      repeat (5) pulse(64'h0000_0004_0000_0000);
      rd_check("cnt_five", 5'h10, 32'd5, OK);
      do_write(5'h10, 32'h0, 4'hF, 1'b1, r);
      rd_check("cnt_clr_and_strobe", 5'h10, 32'd1, OK);
      force dut.upd_cnt = 32'hFFFF_FFFF;
      @(posedge axi_aclk);
      #1;
      release dut.upd_cnt;
      pulse(64'h0000_0005_0000_0000);
      rd_check("cnt_wrap", 5'h10, 32'd0, OK);
`else
      rd_check("cnt_absent", 5'h10, 32'h0, ERR);
`endif

      // Leave a sticky bit set, then reset while a write response is pending.
      sync_ok = 1'b0;
      idle(5);
      sync_ok = 1'b1;
      idle(5);
      rd_check("sticky_before_reset", 5'h04, 32'h7, OK);
      begin
         int n = 0;
         axi.bready  = 1'b0;
         axi.awaddr  = 5'h04;
         axi.wdata   = 32'h0;
         axi.wstrb   = 4'hF;
         axi.awvalid = 1'b1;
         axi.wvalid  = 1'b1;
         do begin @(negedge axi_aclk); n++; end while (!axi.bvalid && n < TMO);
         axi.awvalid = 1'b0;
         axi.wvalid  = 1'b0;
         if (!axi.bvalid) timeout("pending_bvalid");
         @(posedge axi_aclk);
         #1;
         axi_aresetn = 1'b0;
         @(posedge axi_aclk);
         @(negedge axi_aclk);
         check("mid_txn_reset_outputs", {23'd0, all_outputs()}, 64'd0);
         axi.bready = 1'b1;
         @(posedge axi_aclk);
         #1;
         axi_aresetn = 1'b1;
         rd_check("status_after_reset_2", 5'h04, 32'h0, OK);
         check("no_resp_after_reset", {63'd0, axi.bvalid}, 64'd0);
         idle(4);
         rd_check("sticky_cleared_by_reset", 5'h04, 32'h3, OK);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
